// File: rtl/botones_pkg.sv
// Shared types and width helpers for the push-button conditioner.
// Pure declarations: no logic, no latency, no flow control.
package botones_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } estado_boton_t;

  // Never returns 0, so a counter sized from a tiny limit still has one bit.
  function automatic int ancho_cnt(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/canal_debounce.sv
// One button channel: 2-flop synchroniser, debounce FSM, registered pulse/level; accepts an edge
// DEBOUNCE_CYCLES+3 clocks after the first sample, no backpressure. BOTONES_AUTOREPEAT_EN adds repeat pulses.
module canal_debounce
  import botones_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 16,
  parameter int PULSE_ON_RELEASE = 1,
  parameter int HOLD_CYCLES      = 1000,
  parameter int REPEAT_CYCLES    = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic boton,
  output logic pulso,
  output logic pulsado
);

  localparam int             CW      = ancho_cnt(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_FIN = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2;
  estado_boton_t estado, estado_sig;
  logic [CW-1:0] cnt, cnt_sig;
  logic          pulso_sig, pulsado_sig;

`ifdef BOTONES_AUTOREPEAT_EN
  localparam int            RW       = ancho_cnt(max_int(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [RW-1:0] HOLD_FIN = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_FIN  = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rcnt, rcnt_sig;
  logic          repitiendo, repitiendo_sig;
`else
  logic unused_cfg;
  assign unused_cfg = (HOLD_CYCLES + REPEAT_CYCLES) > 0;
`endif

  always_comb begin
    estado_sig  = estado;
    cnt_sig     = cnt;
    pulsado_sig = pulsado;
    pulso_sig   = 1'b0;
    unique case (estado)
      IDLE: begin
        if (s2) begin
          estado_sig = PRESS_DB;
          cnt_sig    = '0;
        end
      end
      PRESS_DB: begin
        if (!s2) begin
          estado_sig = IDLE;
        end else if (cnt == CNT_FIN) begin
          estado_sig  = HELD;
          pulsado_sig = 1'b1;
          pulso_sig   = (PULSE_ON_RELEASE == 0);
        end else begin
          cnt_sig = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!s2) begin
          estado_sig = RELEASE_DB;
          cnt_sig    = '0;
        end
      end
      RELEASE_DB: begin
        if (s2) begin
          estado_sig = HELD;
        end else if (cnt == CNT_FIN) begin
          estado_sig  = IDLE;
          pulsado_sig = 1'b0;
          pulso_sig   = (PULSE_ON_RELEASE != 0);
        end else begin
          cnt_sig = cnt + 1'b1;
        end
      end
      default: estado_sig = IDLE;
    endcase

`ifdef BOTONES_AUTOREPEAT_EN
    // The repeat counter only advances while staying in HELD; a bounce freezes it.
    rcnt_sig       = rcnt;
    repitiendo_sig = repitiendo;
    if (estado == PRESS_DB && estado_sig == HELD) begin
      rcnt_sig       = '0;
      repitiendo_sig = 1'b0;
    end else if (estado == HELD && s2) begin
      if ((!repitiendo && rcnt == HOLD_FIN) || (repitiendo && rcnt == REP_FIN)) begin
        pulso_sig      = 1'b1;
        rcnt_sig       = '0;
        repitiendo_sig = 1'b1;
      end else begin
        rcnt_sig = rcnt + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      estado  <= IDLE;
      cnt     <= '0;
      pulso   <= 1'b0;
      pulsado <= 1'b0;
    end else begin
      s1      <= boton;
      s2      <= s1;
      estado  <= estado_sig;
      cnt     <= cnt_sig;
      pulso   <= pulso_sig;
      pulsado <= pulsado_sig;
    end
  end

`ifdef BOTONES_AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt       <= '0;
      repitiendo <= 1'b0;
    end else begin
      rcnt       <= rcnt_sig;
      repitiendo <= repitiendo_sig;
    end
  end
`endif

endmodule

// File: rtl/botones_a_pulsos.sv
// N_CH independent debounced buttons to one-cycle pulses plus levels and an any-event flag.
// Latency DEBOUNCE_CYCLES+3 clocks per edge, no backpressure; BOTONES_AUTOREPEAT_EN enables hold-repeat.
module botones_a_pulsos
  import botones_pkg::*;
#(
  parameter int N_CH             = 4,
  parameter int DEBOUNCE_CYCLES  = 16,
  parameter int PULSE_ON_RELEASE = 1,
  parameter int HOLD_CYCLES      = 1000,
  parameter int REPEAT_CYCLES    = 200
) (
  input  logic            clck_i,
  input  logic            rst_i,
  input  logic [N_CH-1:0] boton_i,
  output logic [N_CH-1:0] pulso_o,
  output logic [N_CH-1:0] pulsado_o,
  output logic            evento_o
);

  for (genvar g = 0; g < N_CH; g++) begin : g_canal
    canal_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .PULSE_ON_RELEASE(PULSE_ON_RELEASE),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_canal (
      .clk    (clck_i),
      .rst    (rst_i),
      .boton  (boton_i[g]),
      .pulso  (pulso_o[g]),
      .pulsado(pulsado_o[g])
    );
  end

  assign evento_o = |pulso_o;

endmodule
